// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M-style multiply/divide unit. The default build is an iterative
// shift-add / restoring divider. Defining MULDIV_FAST_MUL_EN adds a single-cycle multiply.
// Ports: clk, reset_n (async, active-low), start, funct3, a, b, flush -> busy, done, result.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state;
  logic [2:0]         op;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   opd;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic             is_div;
  logic             sgn_a;
  logic             sgn_b;
  logic             dz;
  logic             ovf;
  logic             early;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] early_res;

  always_comb begin
    is_div = funct3[2];
    sgn_a = (funct3 == 3'b001) | (funct3 == 3'b010)
          | (is_div & ~funct3[0]);
    sgn_b = (funct3 == 3'b001) | (is_div & ~funct3[0]);
    a_mag = (sgn_a & a[WIDTH-1]) ? -a : a;
    b_mag = (sgn_b & b[WIDTH-1]) ? -b : b;
    dz = is_div & (b == '0);
    ovf = is_div & ~funct3[0] & (a == MINV) & (b == ONES);
    early = dz | ovf;
    if (dz)
      early_res = funct3[1] ? a : ONES;
    else
      early_res = funct3[1] ? '0 : MINV;
  end

  logic             fast;
  logic [WIDTH-1:0] fast_res;

`ifdef MULDIV_FAST_MUL_EN
  // Extending to 2*WIDTH keeps the low 2*WIDTH product bits exact for every signedness mix.
  logic [2*WIDTH-1:0] ax;
  logic [2*WIDTH-1:0] bx;
  logic [2*WIDTH-1:0] fprod;

  always_comb begin
    ax = {{WIDTH{sgn_a & a[WIDTH-1]}}, a};
    bx = {{WIDTH{sgn_b & b[WIDTH-1]}}, b};
    fprod = ax * bx;
    fast = ~is_div;
    fast_res = (funct3[1:0] == 2'b00) ? fprod[WIDTH-1:0]
                                       : fprod[2*WIDTH-1:WIDTH];
  end
`else
  always_comb begin
    fast = 1'b0;
    fast_res = '0;
  end
`endif

  // acc holds {hi, lo}. Multiply: hi = partial sum, lo = multiplier.
  // Divide: hi = partial remainder, lo = dividend shifting into the quotient.
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     tmp;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
        + {1'b0, {WIDTH{acc[0]}} & opd};
    tmp = acc[2*WIDTH-1:WIDTH-1];
    diff = tmp - {1'b0, opd};
    if (op[2])
      step = {(diff[WIDTH] ? tmp[WIDTH-1:0] : diff[WIDTH-1:0]),
              acc[WIDTH-2:0], ~diff[WIDTH]};
    else
      step = {sum, acc[WIDTH-1:1]};
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_res;

  always_comb begin
    prod = (sa ^ sb) ? -acc : acc;
    quo = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (op[2])
      fix_res = op[1] ? rem : quo;
    else
      fix_res = (op[1:0] == 2'b00) ? prod[WIDTH-1:0]
                                   : prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opd    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op  <= funct3;
            sa  <= sgn_a & a[WIDTH-1];
            sb  <= sgn_b & b[WIDTH-1];
            cnt <= '0;
            opd <= is_div ? b_mag : a_mag;
            acc <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            if (early) begin
              result <= early_res;
              state  <= S_DONE;
            end else if (fast) begin
              result <= fast_res;
              state  <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= step;
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
              state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            result <= fix_res;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32).
// Covers iterative/early-out latency, signed corners, flush, mid-op reset.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
  localparam logic [2:0] RST_OP = F_DIVU;
`else
  localparam int ML = 34;
  localparam logic [2:0] RST_OP = F_MUL;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .funct3(funct3), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f,
                       input logic [31:0] x,
                       input logic [31:0] y);
    start = 1'b1;
    funct3 = f;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(input string tag,
                           input logic [31:0] exp,
                           input int lat);
    int n;
    int lows;
    n = 1;
    lows = 0;
    while (!done && n < 200) begin
      if (!busy) lows++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!busy) lows++;
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check(tag, {32'h0, result}, {32'h0, exp});
    check({tag, "_busy"}, 64'(lows), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_idle"}, {63'h0, busy | done}, 64'd0);
  endtask

  task automatic do_op(input string tag,
                       input logic [2:0] f,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [31:0] exp,
                       input int lat);
    issue(f, x, y);
    wait_done(tag, exp, lat);
  endtask

  initial begin
    int dn;
    #1;
    reset_n = 1'b0;
    #2;
    check("rst0_busy", {63'h0, busy}, 64'd0);
    check("rst0_done", {63'h0, done}, 64'd0);
    check("rst0_res", {32'h0, result}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_op("mul", F_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, ML);
    do_op("mulh", F_MULH, 32'h80000000, 32'h80000000,
          32'h40000000, ML);
    do_op("mulhu", F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, ML);
    do_op("mulhsu", F_MULHSU, 32'hFFFFFFFF, 32'd2,
          32'hFFFFFFFF, ML);
    do_op("div", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    do_op("rem", F_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    do_op("div_nn", F_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 34);
    do_op("rem_pn", F_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
    do_op("divu", F_DIVU, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu", F_REMU, 32'd100, 32'd7, 32'd2, 34);
    do_op("divu_z", F_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    do_op("remu_z", F_REMU, 32'd5, 32'd0, 32'd5, 1);
    do_op("div_z", F_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1);
    do_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF,
          32'h80000000, 1);
    do_op("rem_ovf", F_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    // flush with start in IDLE drops the request
    do_op("remu_pre", F_REMU, 32'd100, 32'd7, 32'd2, 34);
    start = 1'b1;
    flush = 1'b1;
    funct3 = F_DIVU;
    a = 32'd9;
    b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("drop_busy", {63'h0, busy | done}, 64'd0);
    check("drop_res", {32'h0, result}, 64'd2);

    // mid-op re-start is ignored, flush aborts without done
    issue(F_DIV, 32'd1000, 32'd3);
    dn = 0;
    for (int k = 1; k <= 11; k++) begin
      if (done) dn++;
      if (k == 10) check("fl_busy10", {63'h0, busy}, 64'd1);
      if (k == 11) check("fl_busy11", {63'h0, busy}, 64'd0);
      start = (k == 5);
      funct3 = F_DIVU;
      a = 32'd50;
      b = 32'd0;
      flush = (k == 10);
      @(posedge clk);
      #1;
    end
    if (done) dn++;
    start = 1'b0;
    flush = 1'b0;
    check("fl_nodone", 64'(dn), 64'd0);
    check("fl_busy12", {63'h0, busy}, 64'd0);
    check("fl_res", {32'h0, result}, 64'd2);
    do_op("fl_next", F_DIV, 32'd1000, 32'd3, 32'd333, 34);

    // reset in cycle 15 of an operation
    issue(RST_OP, 32'd100, 32'd7);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    check("rst_pre", {63'h0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_busy", {63'h0, busy}, 64'd0);
    check("rst_done", {63'h0, done}, 64'd0);
    check("rst_res", {32'h0, result}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done | busy) dn++;
    end
    check("rst_nodone", 64'(dn), 64'd0);
    check("rst_res2", {32'h0, result}, 64'd0);
    do_op("mul34", F_MUL, 32'd3, 32'd4, 32'd12, ML);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (even, >= 8).
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request strobe; accepted only when busy=0.
REQ-005 funct3  input  3  RV M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 a  input  WIDTH  operand rs1 (multiplicand/dividend).
REQ-007 b  input  WIDTH  operand rs2 (multiplier/divisor).
REQ-008 flush  input  1  abort the in-flight operation (pipeline squash).
REQ-009 busy  output  1  high from the cycle after acceptance through the done cycle.
REQ-010 done  output  1  one-cycle pulse; result valid this cycle.
REQ-011 result  output  WIDTH  registered result; held until the next done.

Function
REQ-012 States: IDLE, CALC, FIXUP, DONE; encoding is free.
REQ-013 IDLE: start=1 latches funct3, a, b and operand signs, then goes to CALC (DONE for early-out or fast multiply).
REQ-014 Inputs are sampled only on the acceptance edge; later input changes have no effect on the operation.
REQ-015 start while busy=1 is ignored: no queuing, no error.
REQ-016 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on magnitudes, WIDTH cycles, via an iteration counter of $clog2(WIDTH)+1 bits.
REQ-017 FIXUP: one cycle; applies sign correction and selects the low or high half (multiply) or quotient/remainder (divide).
REQ-018 DONE: done=1 and result is valid; returns to IDLE on the next edge; busy=0 in the cycle after DONE.
REQ-019 Latency for iterative ops: start accepted at cycle 0 -> done in cycle WIDTH+2.
REQ-020 Early-out when b=0 (all divide ops) or DIV/REM with a=most-negative and b=-1: done in cycle 1, skipping CALC and FIXUP.
REQ-021 Divide by zero: DIV/DIVU return all-ones; REM/REMU return a.
REQ-022 Signed overflow: DIV returns the most-negative value; REM returns 0.
REQ-023 Signed division truncates toward zero; remainder takes the sign of the dividend.
REQ-024 MULH treats both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned. The 2*WIDTH product is exact.
REQ-025 flush=1 in any non-IDLE state forces IDLE on the next edge with done suppressed; result is unchanged.
REQ-026 flush=1 together with start in IDLE: the request is dropped.
REQ-027 flush=1 in the DONE cycle does not retract the done already asserted.

Reset
REQ-028 reset_n=0 immediately forces: state IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
REQ-029 Reset asserted mid-operation abandons the operation; no done follows reset release.
REQ-030 The first start is accepted on the first rising edge with reset_n=1.

Configuration
REQ-031 Macro MULDIV_FAST_MUL_EN.
REQ-032 Defined: multiply ops use a single-cycle combinational WIDTH x WIDTH product and go IDLE->DONE, done in cycle 1; divide ops are unchanged.
REQ-033 Undefined: multiply ops use the iterative path with the REQ-019 latency; no hardware multiplier is inferred.

Verification
REQ-034 WIDTH=32, macro undefined: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 34, busy high cycles 1-34.
REQ-035 MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-037 DIVU a=5, b=0 -> 0xFFFFFFFF with done in cycle 1; REMU a=5, b=0 -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 with done in cycle 1; REM same operands -> 0.
REQ-038 DIV accepted, start re-pulsed in cycle 5, flush in cycle 10 -> busy=0 from cycle 11, no done ever, result keeps its prior value; a new start in cycle 12 completes normally.
REQ-039 reset_n low in cycle 15 of a MUL -> all outputs 0 immediately; no done after release. With the macro defined: MUL 3*4 -> 12 in cycle 1.
